// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of a single-port data memory
//
// Purpose:
//   Serialises accesses from two requesters onto one data memory port.
//   Every transaction takes IDLE -> ACCESS -> RESP (3 cycles).
//   Out-of-range addresses are rejected without strobing the memory.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   reqN, weN, modeN           request, write enable (1 = write), mode (0 = word, 1 = byte)
//   addrN, wdataN              byte address and write data of requester N
//   ackN, errN                 one-cycle completion pulse and out-of-range flag
//   rdataN                     read data, held until that port's next completed read
//   mem_rd, mem_wn             memory read / write strobes (ACCESS only)
//   mem_address, mem_mode      latched address and mode driven to the memory
//   mem_write_data             latched write data driven to the memory
//   mem_read_data              memory read data (word: {byte[a], byte[a+1]})
//   busy                       high whenever the FSM is not IDLE
//
// Configuration:
//   DMEM_ARB_RR_EN             when defined, contention is resolved round-robin;
//                              otherwise port 0 always wins contention.

module data_mem_arbiter #(
    parameter int MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic        mode0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic        mode1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        err0,
    output logic [15:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [15:0] rdata1,
    output logic        mem_rd,
    output logic        mem_wn,
    output logic [15:0] mem_address,
    output logic        mem_mode,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // A word touches addr and addr+1, so its last legal start is one byte lower.
    localparam logic [31:0] BYTE_LIMIT = MEM_BYTES;
    localparam logic [31:0] WORD_LIMIT = MEM_BYTES - 1;

    state_t      state;
    state_t      state_nxt;

    logic        grant_valid;
    logic        grant_sel;
    logic        sel_we;
    logic        sel_mode;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_err;

    logic        cmd_we;
    logic        cmd_mode;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_gnt;
    logic        cmd_err;

    logic        rd_done;
    logic [15:0] rd_value;

`ifdef DMEM_ARB_RR_EN
    // Port granted most recently; reset to 1 so port 0 wins the first contention.
    logic        last_gnt;
`endif

    // Arbitration: choose which requester is latched when leaving IDLE.
    always_comb begin
        grant_valid = req0 | req1;
        grant_sel   = 1'b0;
`ifdef DMEM_ARB_RR_EN
        if (req0 && req1) begin
            grant_sel = ~last_gnt;
        end else begin
            grant_sel = req1;
        end
`else
        grant_sel = ~req0;
`endif
    end

    always_comb begin
        sel_we    = grant_sel ? we1    : we0;
        sel_mode  = grant_sel ? mode1  : mode0;
        sel_addr  = grant_sel ? addr1  : addr0;
        sel_wdata = grant_sel ? wdata1 : wdata0;
        if (sel_mode) begin
            sel_err = ({16'd0, sel_addr} >= BYTE_LIMIT);
        end else begin
            sel_err = ({16'd0, sel_addr} >= WORD_LIMIT);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all FSM-decoded outputs.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wn    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // An erroring command never reaches the memory.
                mem_rd    = ~cmd_we & ~cmd_err;
                mem_wn    =  cmd_we & ~cmd_err;
                state_nxt = RESP;
            end
            RESP: begin
                ack0      = ~cmd_gnt;
                ack1      =  cmd_gnt;
                err0      = ~cmd_gnt & cmd_err;
                err1      =  cmd_gnt & cmd_err;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch: captured once per grant and held through ACCESS and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_we    <= 1'b0;
            cmd_mode  <= 1'b0;
            cmd_addr  <= 16'h0000;
            cmd_wdata <= 16'h0000;
            cmd_gnt   <= 1'b0;
            cmd_err   <= 1'b0;
        end else if (state == IDLE && grant_valid) begin
            cmd_we    <= sel_we;
            cmd_mode  <= sel_mode;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_gnt   <= grant_sel;
            cmd_err   <= sel_err;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_gnt <= grant_sel;
        end
    end
`endif

    assign mem_address    = cmd_addr;
    assign mem_mode       = cmd_mode;
    assign mem_write_data = cmd_wdata;

    // Byte reads return the addressed byte, which the memory places in the high half.
    assign rd_done  = (state == ACCESS) && !cmd_we && !cmd_err;
    assign rd_value = cmd_mode ? {8'h00, mem_read_data[15:8]} : mem_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= 16'h0000;
            rdata1 <= 16'h0000;
        end else if (rd_done) begin
            if (cmd_gnt) begin
                rdata1 <= rd_value;
            end else begin
                rdata0 <= rd_value;
            end
        end
    end

endmodule
